// File: rtl/vdp_cmd_pkg.sv
// Shared definitions for the VDP posted-write command buffer: entry layout and
// upstream FSM encoding.
package vdp_cmd_pkg;

    localparam int ENTRY_W   = 10;
    localparam int DATA_LSB  = 0;
    localparam int DATA_W    = 8;
    localparam int ADDR_LSB  = 8;
    localparam int ADDR_W    = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_DRAIN = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RELEASE  = 3'd4
    } state_e;

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [ADDR_W-1:0] addr,
                                                      input logic [DATA_W-1:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/ip_vdp_cmd_fifo_ram.sv
// Command storage: 2^DEPTH_LOG2 x ENTRY_W, synchronous write, combinational head read.
// Contents are not reset; validity is tracked by the parent's pointers and level.
module ip_vdp_cmd_fifo_ram
    import vdp_cmd_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [ENTRY_W-1:0]    wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [ENTRY_W-1:0]    rdata_o
);

    logic [ENTRY_W-1:0] mem_q [1<<DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ip_vdp_cmd_fifo.sv
// Posted-write buffer between MSX bus and VDP; writes acked next cycle, reads drain FIFO first.
// Latency: write ack N+1, VDP request from N+2; read data returned the cycle after vdp_ack.
// Backpressure: writes stall without ack while full. IP_VDP_CMD_FIFO_STATUS_EN adds level/stall outputs.
module ip_vdp_cmd_fifo
    import vdp_cmd_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                bus_req,
    input  logic                bus_wrt,
    input  logic [1:0]          bus_address,
    input  logic [7:0]          bus_wdata,
    output logic                bus_ack,
    output logic [7:0]          bus_rdata,
    output logic                bus_rdata_en,
    output logic                vdp_req,
    output logic                vdp_wrt,
    output logic [1:0]          vdp_address,
    output logic [7:0]          vdp_wdata,
    input  logic                vdp_ack,
`ifdef IP_VDP_CMD_FIFO_STATUS_EN
    output logic [DEPTH_LOG2:0] fifo_level,
    output logic [15:0]         stall_count,
`endif
    input  logic [7:0]          vdp_rdata
);

    localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
    logic [DEPTH_LOG2:0]   level_q;
    logic                  bus_ack_q, bus_ack_d;
    logic                  rdata_en_q, rdata_en_d;
    logic [7:0]            bus_rdata_q, bus_rdata_d;
    logic                  vdp_req_q, vdp_req_d;
    logic                  vdp_wrt_q, vdp_wrt_d;
    logic [1:0]            vdp_addr_q, vdp_addr_d;
    logic [7:0]            vdp_wdata_q, vdp_wdata_d;
    logic [ENTRY_W-1:0]    head;
    logic                  full, empty, rd_active, push, pop;

    assign full      = (level_q == FULL_LVL);
    assign empty     = (level_q == '0);
    assign rd_active = (state_q == ST_RD_ISSUE) || (state_q == ST_RD_WAIT);
    assign pop       = !rd_active && vdp_req_q && vdp_wrt_q && vdp_ack;
    // A full FIFO still accepts a write in the cycle its head retires.
    assign push      = (state_q == ST_IDLE) && bus_req && bus_wrt && (!full || pop);

    ip_vdp_cmd_fifo_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wptr_q),
        .wdata_i (pack_entry(bus_address, bus_wdata)),
        .raddr_i (rptr_q),
        .rdata_o (head)
    );

    always_comb begin
        state_d     = state_q;
        bus_ack_d   = 1'b0;
        rdata_en_d  = 1'b0;
        bus_rdata_d = bus_rdata_q;
        vdp_req_d   = vdp_req_q;
        vdp_wrt_d   = vdp_wrt_q;
        vdp_addr_d  = vdp_addr_q;
        vdp_wdata_d = vdp_wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus_req && !bus_wrt) begin
                    state_d = ST_RD_DRAIN;
                end else if (push) begin
                    bus_ack_d = 1'b1;
                    state_d   = ST_RELEASE;
                end
            end
            ST_RD_DRAIN: begin
                if (empty && !vdp_req_q) begin
                    vdp_req_d  = 1'b1;
                    vdp_wrt_d  = 1'b0;
                    vdp_addr_d = bus_address;
                    state_d    = ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE, ST_RD_WAIT: begin
                if (vdp_ack) begin
                    bus_rdata_d = vdp_rdata;
                    bus_ack_d   = 1'b1;
                    rdata_en_d  = 1'b1;
                    vdp_req_d   = 1'b0;
                    state_d     = ST_RELEASE;
                end else begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RELEASE: begin
                if (!bus_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pop engine; never competes with the read issue, which requires an empty FIFO.
        if (!rd_active) begin
            if (pop) begin
                vdp_req_d = 1'b0;
            end else if (!vdp_req_q && !empty) begin
                vdp_req_d   = 1'b1;
                vdp_wrt_d   = 1'b1;
                vdp_addr_d  = head[ADDR_LSB +: ADDR_W];
                vdp_wdata_d = head[DATA_LSB +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            bus_ack_q   <= 1'b0;
            rdata_en_q  <= 1'b0;
            bus_rdata_q <= '0;
            vdp_req_q   <= 1'b0;
            vdp_wrt_q   <= 1'b0;
            vdp_addr_q  <= '0;
            vdp_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            bus_ack_q   <= bus_ack_d;
            rdata_en_q  <= rdata_en_d;
            bus_rdata_q <= bus_rdata_d;
            vdp_req_q   <= vdp_req_d;
            vdp_wrt_q   <= vdp_wrt_d;
            vdp_addr_q  <= vdp_addr_d;
            vdp_wdata_q <= vdp_wdata_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push && !pop)      level_q <= level_q + 1'b1;
            else if (pop && !push) level_q <= level_q - 1'b1;
        end
    end

    assign bus_ack      = bus_ack_q;
    assign bus_rdata    = bus_rdata_q;
    assign bus_rdata_en = rdata_en_q;
    assign vdp_req      = vdp_req_q;
    assign vdp_wrt      = vdp_wrt_q;
    assign vdp_address  = vdp_addr_q;
    assign vdp_wdata    = vdp_wdata_q;

`ifdef IP_VDP_CMD_FIFO_STATUS_EN
    logic        stall;
    logic [15:0] stall_q;

    assign stall = (state_q == ST_IDLE) && bus_req && bus_wrt && full && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (stall && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign fifo_level  = level_q;
    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_ip_vdp_cmd_fifo.sv
// Directed self-checking bench for ip_vdp_cmd_fifo with a simple VDP responder.
module tb_ip_vdp_cmd_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bus_req = 1'b0, bus_wrt = 1'b0;
    logic [1:0] bus_address = '0;
    logic [7:0] bus_wdata = '0;
    logic       bus_ack, bus_rdata_en;
    logic [7:0] bus_rdata;
    logic       vdp_req, vdp_wrt;
    logic [1:0] vdp_address;
    logic [7:0] vdp_wdata;
    logic       vdp_ack = 1'b0;
    logic [7:0] vdp_rdata = '0;
`ifdef IP_VDP_CMD_FIFO_STATUS_EN
    logic [3:0]  fifo_level;
    logic [15:0] stall_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // VDP responder controls and log: {wrt, addr, wdata (0 for reads)}
    int          ack_lat = 3;
    bit          vdp_hold = 1'b0;
    logic [7:0]  rd_val = 8'h00;
    logic [10:0] seen[$];
    int          last_ack_cyc = -1;
    int          rd_pending_at_issue = -1;
    int          req_cnt = 0;

    ip_vdp_cmd_fifo #(.DEPTH_LOG2(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus_req      (bus_req),
        .bus_wrt      (bus_wrt),
        .bus_address  (bus_address),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .bus_rdata_en (bus_rdata_en),
        .vdp_req      (vdp_req),
        .vdp_wrt      (vdp_wrt),
        .vdp_address  (vdp_address),
        .vdp_wdata    (vdp_wdata),
        .vdp_ack      (vdp_ack),
`ifdef IP_VDP_CMD_FIFO_STATUS_EN
        .fifo_level   (fifo_level),
        .stall_count  (stall_count),
`endif
        .vdp_rdata    (vdp_rdata)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Acks a request ack_lat cycles after it first appears (unless held off).
    initial forever begin
        @(negedge clk);
        if (reset || !vdp_req) begin
            req_cnt = 0;
            vdp_ack = 1'b0;
        end else begin
            req_cnt++;
            if (req_cnt == 1 && !vdp_wrt) rd_pending_at_issue = seen.size();
            if (req_cnt > ack_lat && !vdp_hold) begin
                vdp_ack   = 1'b1;
                vdp_rdata = rd_val;
                seen.push_back({vdp_wrt, vdp_address, vdp_wrt ? vdp_wdata : 8'h00});
                last_ack_cyc = cyc;
                req_cnt = 0;
            end else begin
                vdp_ack = 1'b0;
            end
        end
    end

    task automatic bus_start(input logic wrt, input logic [1:0] a, input logic [7:0] d);
        bus_req = 1'b1;
        bus_wrt = wrt;
        bus_address = a;
        bus_wdata = d;
    endtask

    // Waits for bus_ack, drops the request, then idles one cycle so RELEASE sees it low.
    task automatic wait_ack(input int budget, output int lat, output int ack_c,
                            output logic [7:0] rd, output logic rd_en);
        lat = -1; ack_c = -1; rd = '0; rd_en = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (bus_ack) begin
                lat = i; ack_c = cyc; rd = bus_rdata; rd_en = bus_rdata_en;
                break;
            end
        end
        bus_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_seen(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (seen.size() >= n) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus_ack, bus_rdata_en, bus_rdata, vdp_req, vdp_wrt, vdp_address, vdp_wdata} !== 20'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0",
                {bus_ack, bus_rdata_en, bus_rdata, vdp_req, vdp_wrt, vdp_address, vdp_wdata});
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({bus_ack, vdp_req} !== 2'b00) begin
            n_fail++; $display("FAIL post_reset_idle: got %b want 00", {bus_ack, vdp_req});
        end
    endtask

    task automatic test_single_write;
        seen.delete(); ack_lat = 3;
        bus_start(1'b1, 2'd1, 8'h99);
        @(posedge clk); #1;
        n_checks++;
        if ({bus_ack, bus_rdata_en, vdp_req} !== 3'b100) begin
            n_fail++; $display("FAIL wr_ack_n1: got ack/en/req %b want 100", {bus_ack, bus_rdata_en, vdp_req});
        end
        bus_req = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({vdp_req, vdp_wrt, vdp_address, vdp_wdata} !== {1'b1, 1'b1, 2'd1, 8'h99}) begin
            n_fail++; $display("FAIL wr_vdp_n2: got %h want %h",
                {vdp_req, vdp_wrt, vdp_address, vdp_wdata}, {1'b1, 1'b1, 2'd1, 8'h99});
        end
        wait_seen(1, 20);
        n_checks++;
        if (vdp_req !== 1'b0) begin
            n_fail++; $display("FAIL wr_req_drop: got %b want 0", vdp_req);
        end
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (seen.size() != 1 || vdp_req !== 1'b0) begin
            n_fail++; $display("FAIL wr_empty_after: got seen=%0d req=%b want 1/0", seen.size(), vdp_req);
        end
    endtask

    task automatic test_fill_stall;
        int lat, ack_c, stalled;
        logic [7:0] rd;
        logic en;
        seen.delete(); ack_lat = 1; vdp_hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus_start(1'b1, 2'd2, 8'(i));
            wait_ack(5, lat, ack_c, rd, en);
            n_checks++;
            if (lat != 1) begin
                n_fail++; $display("FAIL fill_ack_%0d: got lat %0d want 1", i, lat);
            end
        end
        bus_start(1'b1, 2'd2, 8'h08);
        stalled = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus_ack) stalled++;
        end
        n_checks++;
        if (stalled != 0) begin
            n_fail++; $display("FAIL full_stall: got %0d acks want 0", stalled);
        end
        vdp_hold = 1'b0;
        wait_ack(10, lat, ack_c, rd, en);
        n_checks++;
        if (ack_c != last_ack_cyc + 1) begin
            n_fail++; $display("FAIL stall_release: got ack cycle %0d want %0d", ack_c, last_ack_cyc + 1);
        end
        wait_seen(9, 200);
        n_checks++;
        if (seen.size() != 9) begin
            n_fail++; $display("FAIL fill_count: got %0d want 9", seen.size());
        end
        for (int i = 0; i < 9 && i < seen.size(); i++) begin
            n_checks++;
            if (seen[i] !== {1'b1, 2'd2, 8'(i)}) begin
                n_fail++; $display("FAIL fill_order_%0d: got %h want %h", i, seen[i], {1'b1, 2'd2, 8'(i)});
            end
        end
    endtask

    task automatic test_read_ordering;
        int lat, ack_c;
        logic [7:0] rd;
        logic en;
        seen.delete(); ack_lat = 3; rd_val = 8'h5A; rd_pending_at_issue = -1;
        for (int i = 0; i < 3; i++) begin
            bus_start(1'b1, 2'd0, 8'h10 + 8'(i));
            wait_ack(5, lat, ack_c, rd, en);
        end
        bus_start(1'b0, 2'd1, 8'h00);
        wait_ack(200, lat, ack_c, rd, en);
        n_checks++;
        if (rd_pending_at_issue != 3) begin
            n_fail++; $display("FAIL rd_after_writes: got %0d writes done want 3", rd_pending_at_issue);
        end
        n_checks++;
        if ({en, rd} !== {1'b1, 8'h5A}) begin
            n_fail++; $display("FAIL rd_data: got en=%b data=%h want 1/5a", en, rd);
        end
        n_checks++;
        if (ack_c != last_ack_cyc + 1) begin
            n_fail++; $display("FAIL rd_ack_timing: got %0d want %0d", ack_c, last_ack_cyc + 1);
        end
        n_checks++;
        if (seen.size() != 4 || seen[3] !== {1'b0, 2'd1, 8'h00}) begin
            n_fail++; $display("FAIL rd_vdp_cmd: got n=%0d last=%h want 4/100", seen.size(), seen[seen.size()-1]);
        end
        bus_start(1'b1, 2'd0, 8'h20);
        wait_ack(5, lat, ack_c, rd, en);
        n_checks++;
        if ({en, rd} !== {1'b0, 8'h5A}) begin
            n_fail++; $display("FAIL rdata_hold: got en=%b data=%h want 0/5a", en, rd);
        end
        wait_seen(5, 50);
    endtask

    task automatic test_read_empty;
        int lat, ack_c;
        logic [7:0] rd;
        logic en;
        ack_lat = 2; rd_val = 8'hC3;
        @(posedge clk); #1;
        bus_start(1'b0, 2'd3, 8'h00);
        @(posedge clk); #1;
        n_checks++;
        if (vdp_req !== 1'b0) begin
            n_fail++; $display("FAIL rd_empty_n1: got req %b want 0", vdp_req);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({vdp_req, vdp_wrt, vdp_address} !== {1'b1, 1'b0, 2'd3}) begin
            n_fail++; $display("FAIL rd_empty_n2: got %b want 1011", {vdp_req, vdp_wrt, vdp_address});
        end
        wait_ack(20, lat, ack_c, rd, en);
        n_checks++;
        if (lat != 3 || rd !== 8'hC3 || en !== 1'b1) begin
            n_fail++; $display("FAIL rd_empty_data: got lat=%0d data=%h en=%b want 3/c3/1", lat, rd, en);
        end
        n_checks++;
        if (vdp_req !== 1'b0) begin
            n_fail++; $display("FAIL rd_req_drop: got %b want 0", vdp_req);
        end
    endtask

    task automatic test_held_request;
        int acks;
        seen.delete(); ack_lat = 1; acks = 0;
        bus_start(1'b1, 2'd3, 8'h77);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus_ack) break;
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus_ack) acks++;
        end
        bus_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (acks != 0 || seen.size() != 1) begin
            n_fail++; $display("FAIL held_req: got extra acks=%0d pushes=%0d want 0/1", acks, seen.size());
        end
    endtask

    task automatic test_reset_mid;
        int lat, ack_c, reqs;
        logic [7:0] rd;
        logic en;
        vdp_hold = 1'b1; ack_lat = 1;
        for (int i = 0; i < 4; i++) begin
            bus_start(1'b1, 2'd2, 8'h40 + 8'(i));
            wait_ack(5, lat, ack_c, rd, en);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({bus_ack, bus_rdata_en, bus_rdata, vdp_req, vdp_wrt, vdp_address, vdp_wdata} !== 20'h0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got %h want 0",
                {bus_ack, bus_rdata_en, bus_rdata, vdp_req, vdp_wrt, vdp_address, vdp_wdata});
        end
        repeat (2) @(posedge clk);
        #1;
        vdp_hold = 1'b0;
        reset = 1'b0;
        seen.delete();
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (vdp_req) reqs++;
        end
        n_checks++;
        if (reqs != 0) begin
            n_fail++; $display("FAIL reset_discard: got %0d req cycles want 0", reqs);
        end
        bus_start(1'b1, 2'd1, 8'h55);
        wait_ack(5, lat, ack_c, rd, en);
        wait_seen(1, 20);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (seen.size() != 1 || seen[0] !== {1'b1, 2'd1, 8'h55}) begin
            n_fail++; $display("FAIL reset_new_write: got n=%0d first=%h want 1/355", seen.size(), seen[0]);
        end
    endtask

`ifdef IP_VDP_CMD_FIFO_STATUS_EN
    task automatic test_status;
        int lat, ack_c;
        logic [7:0] rd;
        logic en;
        n_checks++;
        if (fifo_level !== 4'd0 || stall_count !== 16'd0) begin
            n_fail++; $display("FAIL status_init: got lvl=%0d stall=%0d want 0/0", fifo_level, stall_count);
        end
        seen.delete(); vdp_hold = 1'b1; ack_lat = 1;
        for (int i = 0; i < 8; i++) begin
            bus_start(1'b1, 2'd0, 8'h80 + 8'(i));
            wait_ack(5, lat, ack_c, rd, en);
        end
        bus_start(1'b1, 2'd0, 8'h88);
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (fifo_level !== 4'd8 || stall_count !== 16'd5 || bus_ack !== 1'b0) begin
            n_fail++; $display("FAIL status_full: got lvl=%0d stall=%0d ack=%b want 8/5/0",
                fifo_level, stall_count, bus_ack);
        end
        vdp_hold = 1'b0;
        wait_ack(10, lat, ack_c, rd, en);
        wait_seen(9, 200);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (fifo_level !== 4'd0 || stall_count !== 16'd5) begin
            n_fail++; $display("FAIL status_drain: got lvl=%0d stall=%0d want 0/5", fifo_level, stall_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_fill_stall();
        test_read_ordering();
        test_read_empty();
        test_held_request();
        test_reset_mid();
`ifdef IP_VDP_CMD_FIFO_STATUS_EN
        test_status();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ip_vdp_cmd_fifo.md
# ip_vdp_cmd_fifo

Posted-write command buffer between the MSX bus front-end (ip_msxbus) and the V9958 clone (vdp_inst). Accepts I/O requests from the bus side, acknowledges writes immediately into a FIFO so the Z80 is never held while the VDP is busy (e.g. during initial SDRAM busy), and replays them to the VDP in order. Reads are strictly ordered behind all pending writes: the FIFO is drained, then the read is issued and its data returned upstream.

## Interface
- DEPTH_LOG2, 3: FIFO depth = 2^DEPTH_LOG2 entries (legal range 1..5).
- clk  in  1  system clock (85.9 MHz PLL output).
- reset  in  1  asynchronous, active-high reset.
- bus_req  in  1  upstream request; held with its fields stable until bus_ack.
- bus_wrt  in  1  1 = write, 0 = read.
- bus_address  in  2  VDP port number.
- bus_wdata  in  8  write data.
- bus_ack  out  1  one-cycle acknowledge to upstream.
- bus_rdata  out  8  read data, valid when bus_rdata_en = 1.
- bus_rdata_en  out  1  one-cycle pulse coincident with a read's bus_ack.
- vdp_req  out  1  downstream request; held until vdp_ack.
- vdp_wrt  out  1  downstream direction.
- vdp_address  out  2  downstream port number.
- vdp_wdata  out  8  downstream write data.
- vdp_ack  in  1  one-cycle acknowledge from VDP.
- vdp_rdata  in  8  VDP read data, valid with vdp_ack on a read.

## Operation
- Entry = {address[1:0], wdata[7:0]}, 10 bits; only writes are stored.
- Upstream FSM: IDLE, RD_DRAIN, RD_ISSUE, RD_WAIT, RELEASE.
  - IDLE: bus_req & bus_wrt & !full -> push entry, pulse bus_ack, go RELEASE. bus_req & bus_wrt & full -> stay, no ack (stall) until a pop frees a slot. bus_req & !bus_wrt -> RD_DRAIN.
  - RD_DRAIN: wait until FIFO empty and no downstream write in flight -> RD_ISSUE.
  - RD_ISSUE: drive vdp_req=1, vdp_wrt=0, vdp_address=bus_address -> RD_WAIT.
  - RD_WAIT: on vdp_ack capture vdp_rdata into bus_rdata, pulse bus_ack and bus_rdata_en, drop vdp_req -> RELEASE.
  - RELEASE: ignore bus_req until it is sampled low for one cycle -> IDLE (guards against double accept of a held request).
- Downstream pop engine (active when upstream FSM not in RD_ISSUE/RD_WAIT): FIFO non-empty and vdp_req=0 -> load head into vdp_address/vdp_wdata, vdp_wrt=1, vdp_req=1. On vdp_ack: vdp_req=0, pop head.
- Simultaneous push and pop: level unchanged, both take effect.
- Pointers wrap modulo 2^DEPTH_LOG2; level is DEPTH_LOG2+1 bits; full = level == 2^DEPTH_LOG2, empty = level == 0.
- vdp_ack while vdp_req=0 is ignored.

## Timing
- Reset (async assert, sync release): all outputs 0, FIFO empty, FSM IDLE, pending contents discarded; reset mid-transaction aborts without ack.
- Write: bus_req sampled in cycle N (not full) -> bus_ack high in N+1; entry poppable from N+2; vdp_req high at earliest N+2.
- Write throughput downstream: one write per (vdp_ack latency + 1) cycles; vdp_req low for at least one cycle between writes.
- Read with empty FIFO: bus_req at N -> RD_DRAIN N+1 -> vdp_req high N+2; vdp_ack at M -> bus_ack/bus_rdata_en at M+1, vdp_req low at M+1.
- bus_rdata holds last read value until the next read completes.

## Configuration
- IP_VDP_CMD_FIFO_STATUS_EN defined: adds outputs fifo_level (DEPTH_LOG2+1 bits, current occupancy) and stall_count (16 bits, saturating count of cycles a write was held because full; cleared by reset). Used for LED/debug hookup.
- Not defined: ports and counters absent; functional behaviour identical.

## Structure
- Package vdp_cmd_pkg: entry width constant (10), FSM state encoding, entry field offsets.
- Sub-module ip_vdp_cmd_fifo_ram: 2^DEPTH_LOG2 x 10 storage with write-pointer write, combinational head read; pointers/level stay in the parent.

## Test plan
- Single write 0x99 to port 1, vdp_ack 3 cycles after vdp_req -> bus_ack at N+1; vdp_req at N+2 with addr=1, wdata=0x99, wrt=1; FIFO empty after ack.
- DEPTH_LOG2=3, vdp_ack held off, 9 writes 0x00..0x08 -> first 8 acked, 9th stalls; release vdp_ack -> 9th acked one cycle after first pop; VDP sees 0x00..0x08 in order.
- 3 queued writes then read of port 1, vdp_rdata=0x5A -> read vdp_req only after third write acked; bus_rdata=0x5A with bus_rdata_en pulse.
- bus_req held high 4 cycles after bus_ack -> exactly one FIFO push.
- Assert reset with 4 entries queued and vdp_req high -> all outputs 0 immediately, no further vdp_req after release until new bus_req.
- With IP_VDP_CMD_FIFO_STATUS_EN, fill FIFO, hold 5 extra stall cycles -> fifo_level=8, stall_count=5.
